// File: rtl/id_stage_param.sv
// MIPS decode stage: regfile, EX>MEM>WB forwarding, branch resolve, load-use stall, trap request FSM.
// ID/EX is registered (1 cycle); stall holds IF/ID and bubbles ID/EX; trap_req holds until trap_ack.
module id_stage_param #(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int LOAD_LAT = 1,
  parameter int TRAP_EN  = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [31:0]   i_instr_id,
  input  logic [DW-1:0] i_pc4_id,
  input  logic          i_id_valid,
  input  logic [4:0]    i_alucode_id,
  input  logic          i_uses_rt,
  input  logic          i_flush_id,
  input  logic          i_ex_we,
  input  logic          i_ex_memread,
  input  logic [AW-1:0] i_ex_addr,
  input  logic [DW-1:0] i_ex_result,
  input  logic          i_mem_we,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_data,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_trap_ack,
  output logic          o_stall,
  output logic          o_pc_write,
  output logic          o_br_taken,
  output logic [DW-1:0] o_br_addr,
  output logic          o_trap_req,
  output logic [DW-1:0] o_trap_pc,
  output logic          o_ex_valid,
  output logic [DW-1:0] o_ex_rs_data,
  output logic [DW-1:0] o_ex_rt_data,
  output logic [DW-1:0] o_ex_imm,
  output logic [AW-1:0] o_ex_rs_addr,
  output logic [AW-1:0] o_ex_rt_addr,
  output logic [AW-1:0] o_ex_rd_addr
);
  localparam logic [1:0] LP_CNT_INIT = 2'(LOAD_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DRAIN} trap_st_t;

  trap_st_t      r_state;
  logic [DW-1:0] r_rf [NREG];
  logic [1:0]    r_cnt;
  logic          r_trap_req;
  logic [DW-1:0] r_trap_pc;
  logic          r_ex_valid;
  logic [DW-1:0] r_ex_rs_data, r_ex_rt_data, r_ex_imm;
  logic [AW-1:0] r_ex_rs_addr, r_ex_rt_addr, r_ex_rd_addr;

  logic [AW-1:0] w_rs, w_rt, w_rd;
  logic [DW-1:0] w_imm, w_a, w_b;
  logic [5:0]    w_op, w_funct;
  logic          w_haz, w_stall, w_cond, w_tcond, w_trap_det;

  assign w_rs    = AW'(i_instr_id[25:21]);
  assign w_rt    = AW'(i_instr_id[20:16]);
  assign w_rd    = AW'(i_instr_id[15:11]);
  assign w_op    = i_instr_id[31:26];
  assign w_funct = i_instr_id[5:0];
  assign w_imm   = {{(DW-16){i_instr_id[15]}}, i_instr_id[15:0]};

  // A load still in EX has no data yet, so it is never a forwarding source.
  always_comb begin
    if (i_ex_we && !i_ex_memread && i_ex_addr != '0 && i_ex_addr == w_rs) w_a = i_ex_result;
    else if (i_mem_we && i_mem_addr != '0 && i_mem_addr == w_rs)          w_a = i_mem_data;
    else if (i_wb_we && i_wb_addr != '0 && i_wb_addr == w_rs)             w_a = i_wb_data;
    else if (w_rs == '0)                                                  w_a = '0;
    else                                                                  w_a = r_rf[w_rs];
  end

  always_comb begin
    if (i_ex_we && !i_ex_memread && i_ex_addr != '0 && i_ex_addr == w_rt) w_b = i_ex_result;
    else if (i_mem_we && i_mem_addr != '0 && i_mem_addr == w_rt)          w_b = i_mem_data;
    else if (i_wb_we && i_wb_addr != '0 && i_wb_addr == w_rt)             w_b = i_wb_data;
    else if (w_rt == '0)                                                  w_b = '0;
    else                                                                  w_b = r_rf[w_rt];
  end

  assign w_haz = i_ex_memread && i_ex_addr != '0 && i_id_valid &&
                 (i_ex_addr == w_rs || (i_uses_rt && i_ex_addr == w_rt));
  assign w_stall = w_haz || r_cnt != 2'd0 || r_state != ST_IDLE;

  always_comb begin
    w_cond = 1'b0;
    case (i_alucode_id)
      5'b01010: w_cond = (w_a == w_b);
      5'b01011: w_cond = (w_a != w_b);
      5'b01100: w_cond = !w_a[DW-1];
      5'b01101: w_cond = !w_a[DW-1] && w_a != '0;
      5'b01110: w_cond = w_a[DW-1] || w_a == '0;
      5'b01111: w_cond = w_a[DW-1];
      default:  w_cond = 1'b0;
    endcase
  end

  assign o_br_taken = w_cond && i_id_valid && !w_stall && !i_flush_id;
  assign o_br_addr  = i_pc4_id + {w_imm[DW-3:0], 2'b00};

  always_comb begin
    w_tcond = 1'b0;
    if (w_op == 6'b000000) begin
      case (w_funct)
        6'b110100: w_tcond = (w_a == w_b);
        6'b110110: w_tcond = (w_a != w_b);
        6'b110000: w_tcond = ($signed(w_a) >= $signed(w_b));
        6'b110001: w_tcond = (w_a >= w_b);
        6'b110010: w_tcond = ($signed(w_a) < $signed(w_b));
        6'b110011: w_tcond = (w_a < w_b);
        default:   w_tcond = 1'b0;
      endcase
    end else if (w_op == 6'b000001) begin
      case (i_instr_id[20:16])
        5'b01100: w_tcond = (w_a == w_imm);
        5'b01110: w_tcond = (w_a != w_imm);
        5'b01000: w_tcond = ($signed(w_a) >= $signed(w_imm));
        5'b01001: w_tcond = (w_a >= w_imm);
        5'b01010: w_tcond = ($signed(w_a) < $signed(w_imm));
        5'b01011: w_tcond = (w_a < w_imm);
        default:  w_tcond = 1'b0;
      endcase
    end
  end

  assign w_trap_det = (TRAP_EN != 0) && w_tcond && i_id_valid && !w_stall;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (i_wb_we && i_wb_addr != '0) begin
      r_rf[i_wb_addr] <= i_wb_data;
    end
  end

  // The first stall cycle comes from the live hazard; the counter covers the rest.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                      r_cnt <= 2'd0;
    else if (w_haz && r_cnt == 2'd0)  r_cnt <= LP_CNT_INIT;
    else if (r_cnt != 2'd0)           r_cnt <= r_cnt - 2'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_trap_req <= 1'b0;
      r_trap_pc  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_trap_det) begin
          r_state    <= ST_REQ;
          r_trap_req <= 1'b1;
          r_trap_pc  <= i_pc4_id - DW'(4);
        end
        ST_REQ: if (i_trap_ack) begin
          r_state    <= ST_DRAIN;
          r_trap_req <= 1'b0;
        end
        ST_DRAIN: r_state <= ST_IDLE;
        default: begin
          r_state    <= ST_IDLE;
          r_trap_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ex_valid   <= 1'b0;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_imm     <= '0;
      r_ex_rs_addr <= '0;
      r_ex_rt_addr <= '0;
      r_ex_rd_addr <= '0;
    end else if (i_flush_id || w_stall || w_trap_det) begin
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_valid   <= i_id_valid;
      r_ex_rs_data <= w_a;
      r_ex_rt_data <= w_b;
      r_ex_imm     <= w_imm;
      r_ex_rs_addr <= w_rs;
      r_ex_rt_addr <= w_rt;
      r_ex_rd_addr <= w_rd;
    end
  end

  assign o_stall      = w_stall;
  assign o_pc_write   = !w_stall;
  assign o_trap_req   = r_trap_req;
  assign o_trap_pc    = r_trap_pc;
  assign o_ex_valid   = r_ex_valid;
  assign o_ex_rs_data = r_ex_rs_data;
  assign o_ex_rt_data = r_ex_rt_data;
  assign o_ex_imm     = r_ex_imm;
  assign o_ex_rs_addr = r_ex_rs_addr;
  assign o_ex_rt_addr = r_ex_rt_addr;
  assign o_ex_rd_addr = r_ex_rd_addr;
endmodule
